fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the CPU core. It generalises the FETCH0/FETCH1/DECODE byte fetch into a pipelined prefetcher with a configurable queue depth and memory read latency. It also supports bus hold and absolute or relative redirect. It sits between the memory bus and the decode/execute state machine, which pops opcode and operand bytes from it instead of driving the program counter directly.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of fetch address and memAddress
- DATA_WIDTH, 8, width of fetched word
- QUEUE_DEPTH, 4, prefetch queue entries (power of two, >= 2)
- MEM_LATENCY, 1, cycles from memRead-asserting edge to memDataR sampling edge (>= 1)
- RESET_PC, 16'h0000, first fetch address after reset

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- memAddress  output  ADDR_WIDTH  fetch address, registered
- memRead  output  1  one-cycle read strobe per issued fetch
- memDataR  input  DATA_WIDTH  read data, valid MEM_LATENCY edges after strobe
- busHold  input  1  core owns bus for data access; no new fetch issued
- fetchValid  output  1  queue head valid
- fetchData  output  DATA_WIDTH  queue head byte
- fetchPC  output  ADDR_WIDTH  address the head byte came from
- fetchReady  input  1  consumer pops head when fetchValid && fetchReady
- jumpEnable  input  1  redirect strobe, one cycle
- jumpAddress  input  ADDR_WIDTH  absolute target / relative base
- jumpRelative  input  1  select relative target (see Configuration)
- jumpOffset  input  8  signed offset for relative redirect

## Operation
- Internal fetch pointer fa, queue count cnt, in-flight pipeline of MEM_LATENCY valid bits plus addresses.
- Issue condition: !busHold && !jumpEnable && (cnt + inflight − pop) < QUEUE_DEPTH. On issue: memAddress<=fa, memRead<=1, fa<=fa+1 mod 2^ADDR_WIDTH (0xFFFF wraps to 0x0000). Otherwise memRead<=0, memAddress holds.
- Return: on the MEM_LATENCY-th edge after an issue edge, if that slot is still valid, push {addr, memDataR} to queue tail.
- Pop: fetchValid && fetchReady removes head; push and pop in same cycle keep cnt unchanged.
- Redirect (jumpEnable=1): queue emptied, all in-flight slots invalidated (their returning data dropped), fa<=target, memRead<=0 that cycle. Redirect wins over simultaneous pop/push. First fetch at target issues on the following edge.
- Bytes delivered strictly in address order, no duplicates, no gaps, between redirects.
- Credit rule guarantees the queue never overflows; no push is ever lost.

## Timing
- Reset values: memAddress=0, memRead=0, fetchValid=0, fetchData=0, fetchPC=0, cnt=0, in-flight all invalid, fa=RESET_PC.
- Reset mid-operation: all in-flight returns discarded; state as above on the next edge.
- Edge E0 = first edge with reset low: memRead=1, memAddress=RESET_PC.
- Head byte visible (fetchValid=1) after edge E0+MEM_LATENCY; redirect-to-first-valid = MEM_LATENCY+1 cycles.
- Sustained 1 byte/cycle when QUEUE_DEPTH >= MEM_LATENCY+1 and consumer always ready.
- busHold sampled each edge; in-flight reads still complete while held.
- fetchData/fetchPC registered from queue head; stable while fetchValid && !fetchReady.

## Configuration
- FETCH_REL_JUMP_EN defined: if jumpRelative=1, target = jumpAddress + sign-extended jumpOffset, mod 2^ADDR_WIDTH. If jumpRelative=0, target = jumpAddress.
- Not defined: jumpRelative and jumpOffset are ignored; target = jumpAddress always. Ports remain present.

## Test plan
- Reset release, memory returns addr[7:0], fetchReady=1, MEM_LATENCY=1 -> memRead at E0 with address 0x0000. fetchValid after E0+1. Bytes 0x00,0x01,0x02… at one per cycle with matching fetchPC.
- fetchReady=0 for 10 cycles, QUEUE_DEPTH=4 -> exactly 4 issues, memRead then low, cnt=4. On release, bytes 0..3 pop, then fetch resumes at 0x0004.
- jumpEnable with jumpAddress=0x0150 while 2 reads in flight -> in-flight data dropped and queue empty. Next fetchPC=0x0150 after MEM_LATENCY+1 cycles.
- FETCH_REL_JUMP_EN: jumpAddress=0x0010, jumpOffset=0xFE, jumpRelative=1 -> next fetchPC=0x000E. Without the macro -> 0x0010.
- busHold high 3 cycles mid-stream -> memRead=0 for those cycles and in-flight bytes still delivered. Stream continues with no gap or duplicate addresses.
- Redirect to 0xFFFE -> fetchPC sequence 0xFFFE, 0xFFFF, 0x0000. Reset asserted mid-stream -> all outputs 0 next edge, restart from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Pipelined instruction prefetcher: credit-limited issue, MEM_LATENCY-deep in-flight tracking, FIFO queue; FETCH_REL_JUMP_EN adds relative redirect.
// Head byte appears MEM_LATENCY+1 edges after a redirect; issue stalls on busHold, redirect or when queue+in-flight would exceed QUEUE_DEPTH.
module fetch_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int QUEUE_DEPTH = 4,
  parameter int MEM_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] memDataR,
  input  logic                  busHold,
  output logic                  fetchValid,
  output logic [DATA_WIDTH-1:0] fetchData,
  output logic [ADDR_WIDTH-1:0] fetchPC,
  input  logic                  fetchReady,
  input  logic                  jumpEnable,
  input  logic [ADDR_WIDTH-1:0] jumpAddress,
  input  logic                  jumpRelative,
  input  logic [7:0]            jumpOffset
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + MEM_LATENCY + 1) + 1;

  logic [ADDR_WIDTH-1:0] r_fa;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_read;
  logic [MEM_LATENCY-1:0] r_inf_vld;
  logic [ADDR_WIDTH-1:0] r_inf_addr [MEM_LATENCY];
  logic [DATA_WIDTH-1:0] r_q_dat [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc  [QUEUE_DEPTH];
  logic [QW-1:0]         r_wr_ptr;
  logic [QW-1:0]         r_rd_ptr;
  logic [QW:0]           r_cnt;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [CW-1:0]         w_inflight;
  logic [CW-1:0]         w_credit;
  logic [ADDR_WIDTH-1:0] w_target;

  assign w_pop  = (r_cnt != '0) && fetchReady;
  assign w_push = r_inf_vld[MEM_LATENCY-1];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      w_inflight = w_inflight + CW'(r_inf_vld[i]);
    end
  end

  // Reads already in flight own a queue slot, so the queue can never overflow.
  assign w_credit = CW'(r_cnt) + w_inflight - CW'(w_pop);
  assign w_issue  = !busHold && !jumpEnable && (w_credit < CW'(QUEUE_DEPTH));

`ifdef FETCH_REL_JUMP_EN
  assign w_target = jumpRelative
                  ? jumpAddress + {{(ADDR_WIDTH-8){jumpOffset[7]}}, jumpOffset}
                  : jumpAddress;
`else
  logic w_unused_rel;
  assign w_unused_rel = jumpRelative ^ (^jumpOffset);
  assign w_target     = jumpAddress;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fa       <= RESET_PC;
      r_mem_addr <= '0;
      r_mem_read <= 1'b0;
      r_inf_vld  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) r_inf_addr[i] <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_dat[i] <= '0;
        r_q_pc[i]  <= '0;
      end
    end else if (jumpEnable) begin
      // Redirect beats any same-cycle push or pop; returning data is dropped.
      r_fa       <= w_target;
      r_mem_read <= 1'b0;
      r_inf_vld  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
    end else begin
      r_mem_read    <= w_issue;
      r_inf_vld[0]  <= w_issue;
      r_inf_addr[0] <= r_fa;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_inf_vld[i]  <= r_inf_vld[i-1];
        r_inf_addr[i] <= r_inf_addr[i-1];
      end
      if (w_issue) begin
        r_mem_addr <= r_fa;
        r_fa       <= r_fa + ADDR_WIDTH'(1);
      end
      if (w_push) begin
        r_q_dat[r_wr_ptr] <= memDataR;
        r_q_pc[r_wr_ptr]  <= r_inf_addr[MEM_LATENCY-1];
        r_wr_ptr          <= r_wr_ptr + QW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + QW'(1);
      end
      r_cnt <= r_cnt + (QW+1)'(w_push) - (QW+1)'(w_pop);
    end
  end

  assign memAddress = r_mem_addr;
  assign memRead    = r_mem_read;
  assign fetchValid = (r_cnt != '0);
  assign fetchData  = r_q_dat[r_rd_ptr];
  assign fetchPC    = r_q_pc[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default parameters): stall, stream, busHold, redirects, wrap, mid-stream reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] memAddress;
  logic        memRead;
  logic [7:0]  memDataR;
  logic        busHold;
  logic        fetchValid;
  logic [7:0]  fetchData;
  logic [15:0] fetchPC;
  logic        fetchReady;
  logic        jumpEnable;
  logic [15:0] jumpAddress;
  logic        jumpRelative;
  logic [7:0]  jumpOffset;

  int          total = 0;
  int          bad = 0;
  int          issues;
  logic [15:0] exp_pc;
  logic [15:0] rel_tgt;

  fetch_unit dut (
    .clk(clk), .reset(reset), .memAddress(memAddress), .memRead(memRead),
    .memDataR(memDataR), .busHold(busHold), .fetchValid(fetchValid),
    .fetchData(fetchData), .fetchPC(fetchPC), .fetchReady(fetchReady),
    .jumpEnable(jumpEnable), .jumpAddress(jumpAddress),
    .jumpRelative(jumpRelative), .jumpOffset(jumpOffset)
  );

  // Memory returns the low address byte; with latency 1 the held address is the one being answered.
  assign memDataR = memAddress[7:0];

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Collect n consecutive bytes (consumer ready), each must continue the address sequence.
  task automatic take(input string tag, input int n);
    int got;
    got = 0;
    for (int c = 0; c < n * 4 + 20 && got < n; c++) begin
      tick();
      if (fetchValid) begin
        chk({tag, "_pc"}, 32'(fetchPC), 32'(exp_pc));
        chk({tag, "_dat"}, 32'(fetchData), 32'(exp_pc[7:0]));
        exp_pc = exp_pc + 16'd1;
        got++;
      end
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  task automatic do_jump(input string tag, input logic [15:0] addr, input logic [7:0] off,
                         input logic rel, input logic [15:0] tgt);
    jumpEnable   = 1'b1;
    jumpAddress  = addr;
    jumpOffset   = off;
    jumpRelative = rel;
    tick();
    chk({tag, "_j_rd"}, 32'(memRead), 32'd0);
    chk({tag, "_j_vld"}, 32'(fetchValid), 32'd0);
    jumpEnable   = 1'b0;
    jumpRelative = 1'b0;
    jumpOffset   = 8'h00;
    tick();
    chk({tag, "_j1_rd"}, 32'(memRead), 32'd1);
    chk({tag, "_j1_addr"}, 32'(memAddress), 32'(tgt));
    chk({tag, "_j1_vld"}, 32'(fetchValid), 32'd0);
    tick();
    chk({tag, "_j2_vld"}, 32'(fetchValid), 32'd1);
    chk({tag, "_j2_pc"}, 32'(fetchPC), 32'(tgt));
    chk({tag, "_j2_dat"}, 32'(fetchData), 32'(tgt[7:0]));
    exp_pc = tgt + 16'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; busHold = 1'b0; fetchReady = 1'b0; jumpEnable = 1'b0;
    jumpAddress = 16'h0000; jumpRelative = 1'b0; jumpOffset = 8'h00;
    exp_pc = 16'h0000;
    repeat (3) tick();
    chk("rst_rd", 32'(memRead), 32'd0);
    chk("rst_addr", 32'(memAddress), 32'd0);
    chk("rst_vld", 32'(fetchValid), 32'd0);
    chk("rst_dat", 32'(fetchData), 32'd0);
    chk("rst_pc", 32'(fetchPC), 32'd0);

    // Consumer stalled from reset release: queue fills with exactly QUEUE_DEPTH reads.
    reset = 1'b0;
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (memRead) issues++;
      if (c == 0) begin
        chk("e0_rd", 32'(memRead), 32'd1);
        chk("e0_addr", 32'(memAddress), 32'h0000);
        chk("e0_vld", 32'(fetchValid), 32'd0);
      end
      if (c == 1) begin
        chk("e1_vld", 32'(fetchValid), 32'd1);
        chk("e1_pc", 32'(fetchPC), 32'h0000);
      end
    end
    chk("stall_issues", 32'(issues), 32'd4);
    chk("stall_rd", 32'(memRead), 32'd0);
    chk("stall_addr", 32'(memAddress), 32'h0003);
    chk("stall_pc", 32'(fetchPC), 32'h0000);
    chk("stall_vld", 32'(fetchValid), 32'd1);

    // Release: head 0 pops on the next edge, stream continues without gaps.
    fetchReady = 1'b1;
    exp_pc = 16'h0001;
    take("stream", 8);

    // busHold: no strobes while held, queued and in-flight bytes keep flowing.
    busHold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("hold_rd", 32'(memRead), 32'd0);
      if (fetchValid) begin
        chk("hold_pc", 32'(fetchPC), 32'(exp_pc));
        exp_pc = exp_pc + 16'd1;
      end
    end
    busHold = 1'b0;
    take("after_hold", 8);

    do_jump("abs", 16'h0150, 8'h00, 1'b0, 16'h0150);
    take("abs_stream", 4);

`ifdef FETCH_REL_JUMP_EN
    rel_tgt = 16'h000E;
`else
    rel_tgt = 16'h0010;
`endif
    do_jump("rel", 16'h0010, 8'hFE, 1'b1, rel_tgt);
    take("rel_stream", 3);

    do_jump("wrap", 16'hFFFE, 8'h00, 1'b0, 16'hFFFE);
    take("wrap_stream", 3);

    // Reset mid-stream.
    reset = 1'b1;
    tick();
    chk("mrst_rd", 32'(memRead), 32'd0);
    chk("mrst_addr", 32'(memAddress), 32'd0);
    chk("mrst_vld", 32'(fetchValid), 32'd0);
    chk("mrst_dat", 32'(fetchData), 32'd0);
    chk("mrst_pc", 32'(fetchPC), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("mrst_e0_rd", 32'(memRead), 32'd1);
    chk("mrst_e0_addr", 32'(memAddress), 32'h0000);
    tick();
    chk("mrst_e1_vld", 32'(fetchValid), 32'd1);
    chk("mrst_e1_pc", 32'(fetchPC), 32'h0000);
    exp_pc = 16'h0001;
    take("mrst_stream", 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
